// File: rtl/sdp_ram_1clk.sv
// sdp_ram_1clk: single-clock simple-dual-port RAM with a registered read (latency 1).
// Define SDP_RAM_BYPASS_EN for write-first forwarding on same-address collisions.
`default_nettype none

module sdp_ram_1clk #(
  parameter int WIDTH = 64,
  parameter int SIZE  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rden,
  input  logic [$clog2(SIZE)-1:0] rdaddr,
  output logic [WIDTH-1:0]        rddata,
  output logic                    rdvalid,
  input  logic                    wren,
  input  logic [$clog2(SIZE)-1:0] wraddr,
  input  logic [WIDTH-1:0]        wrdata
);

  localparam int ADDR_W = $clog2(SIZE);
  localparam logic [ADDR_W:0] DEPTH = SIZE[ADDR_W:0];

  logic [WIDTH-1:0] mem [0:SIZE-1];

  logic             wr_in_range;
  logic             rd_in_range;
  logic [WIDTH-1:0] rd_word;

  assign wr_in_range = ({1'b0, wraddr} < DEPTH);
  assign rd_in_range = ({1'b0, rdaddr} < DEPTH);

  // No reset on the array so it maps onto block RAM; rst_n only gates the write.
  always_ff @(posedge clk) begin
    if (rst_n && wren && wr_in_range) begin
      mem[wraddr] <= wrdata;
    end
  end

`ifdef SDP_RAM_BYPASS_EN
  logic collide;
  assign collide = wren && wr_in_range && (rdaddr == wraddr);
  assign rd_word = collide ? wrdata : mem[rdaddr];
`else
  assign rd_word = mem[rdaddr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rddata  <= '0;
      rdvalid <= 1'b0;
    end else begin
      rdvalid <= rden;
      if (rden) begin
        rddata <= rd_in_range ? rd_word : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdp_ram_1clk.sv
// tb_sdp_ram_1clk: drives a power-of-two (8) and a non-power-of-two (6) instance in lockstep.
`default_nettype none

module tb_sdp_ram_1clk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rden;
  logic [2:0]  rdaddr;
  logic        wren;
  logic [2:0]  wraddr;
  logic [15:0] wrdata;
  logic [15:0] rd8, rd6;
  logic        rv8, rv6;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m8 [8];
  logic [15:0] m6 [6];
  logic [15:0] q8 [$];
  logic [15:0] q6 [$];
  logic [15:0] h8, h6;

  always #5 clk = ~clk;

  sdp_ram_1clk #(.WIDTH(16), .SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .rden(rden), .rdaddr(rdaddr), .rddata(rd8),
    .rdvalid(rv8), .wren(wren), .wraddr(wraddr), .wrdata(wrdata)
  );

  sdp_ram_1clk #(.WIDTH(16), .SIZE(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .rden(rden), .rdaddr(rdaddr), .rddata(rd6),
    .rdvalid(rv6), .wren(wren), .wraddr(wraddr), .wrdata(wrdata)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; expectations go to the scoreboard before the edge.
  task automatic cyc(input logic rd, input logic [2:0] ra,
                     input logic wr, input logic [2:0] wa, input logic [15:0] wd);
    logic [15:0] e8, e6;
    rden = rd; rdaddr = ra; wren = wr; wraddr = wa; wrdata = wd;
    if (rd) begin
      e8 = m8[ra];
      e6 = (ra < 3'd6) ? m6[ra] : 16'h0000;
`ifdef SDP_RAM_BYPASS_EN
      if (wr && wa == ra) begin
        e8 = wd;
        if (ra < 3'd6) e6 = wd;
      end
`endif
      q8.push_back(e8);
      q6.push_back(e6);
    end
    if (wr) begin
      m8[wa] = wd;
      if (wa < 3'd6) m6[wa] = wd;
    end
    @(posedge clk); #1;
    if (rd) begin
      h8 = q8.pop_front();
      h6 = q6.pop_front();
      chk("rdvalid8", {15'b0, rv8}, 16'd1);
      chk("rdvalid6", {15'b0, rv6}, 16'd1);
      chk($sformatf("rddata8@%0d", ra), rd8, h8);
      chk($sformatf("rddata6@%0d", ra), rd6, h6);
    end else begin
      chk("idle_rdvalid8", {15'b0, rv8}, 16'd0);
      chk("idle_rdvalid6", {15'b0, rv6}, 16'd0);
      chk("hold_rddata8", rd8, h8);
      chk("hold_rddata6", rd6, h6);
    end
  endtask

  initial begin
    rst_n = 1'b0; rden = 1'b1; rdaddr = 3'd0; wren = 1'b0; wraddr = 3'd0; wrdata = 16'h0;
    h8 = 16'h0; h6 = 16'h0;

    // Reset held for 3 cycles with reads requested
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_rddata8", rd8, 16'h0);
      chk("rst_rdvalid8", {15'b0, rv8}, 16'd0);
      chk("rst_rddata6", rd6, 16'h0);
      chk("rst_rdvalid6", {15'b0, rv6}, 16'd0);
    end
    rst_n = 1'b1;

    // Write sweep, then back-to-back read sweep (6 and 7 out of range on dut6)
    for (int i = 0; i < 8; i++) cyc(1'b0, 3'd0, 1'b1, 3'(i), 16'hA500 + 16'(i));
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 1'b0, 3'd0, 16'h0);

    // Hold: rddata keeps A503 while addr 3 is rewritten
    cyc(1'b1, 3'd3, 1'b0, 3'd0, 16'h0);
    cyc(1'b0, 3'd0, 1'b1, 3'd3, 16'h1234);
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
    chk("hold_value_A503", rd8, 16'hA503);
    cyc(1'b1, 3'd3, 1'b0, 3'd0, 16'h0);

    // Collision on addr 5, then a plain read of 5
    cyc(1'b1, 3'd5, 1'b1, 3'd5, 16'hBEEF);
`ifdef SDP_RAM_BYPASS_EN
    chk("collision_value", rd8, 16'hBEEF);
`else
    chk("collision_value", rd8, 16'hA505);
`endif
    cyc(1'b1, 3'd5, 1'b0, 3'd0, 16'h0);
    chk("after_collision", rd8, 16'hBEEF);

    // Out-of-range write on dut6 is dropped; dut6 reads 7 as zero
    cyc(1'b0, 3'd0, 1'b1, 3'd7, 16'hFFFF);
    for (int i = 0; i < 6; i++) cyc(1'b1, 3'(i), 1'b0, 3'd0, 16'h0);
    cyc(1'b1, 3'd7, 1'b0, 3'd0, 16'h0);
    chk("oor_read6", rd6, 16'h0000);

    // Retention across a mid-cycle reset pulse; write during reset ignored
    cyc(1'b0, 3'd0, 1'b1, 3'd2, 16'h0C0C);
    cyc(1'b1, 3'd1, 1'b0, 3'd0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rddata8", rd8, 16'h0);
    chk("midrst_rdvalid8", {15'b0, rv8}, 16'd0);
    chk("midrst_rddata6", rd6, 16'h0);
    chk("midrst_rdvalid6", {15'b0, rv6}, 16'd0);
    rden = 1'b1; rdaddr = 3'd2; wren = 1'b1; wraddr = 3'd4; wrdata = 16'hDEAD;
    @(posedge clk); #1;
    chk("inrst_rddata8", rd8, 16'h0);
    chk("inrst_rdvalid8", {15'b0, rv8}, 16'd0);
    rst_n = 1'b1; wren = 1'b0;
    h8 = 16'h0; h6 = 16'h0;
    q8.delete(); q6.delete();
    cyc(1'b1, 3'd2, 1'b0, 3'd0, 16'h0);
    chk("retained_0C0C", rd8, 16'h0C0C);
    cyc(1'b1, 3'd4, 1'b0, 3'd0, 16'h0);
    chk("rst_write_absent", rd8, 16'hA504);
    cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
